// File: rtl/vmc_pkg.sv
// vmc_pkg
//   Shared types and helpers for the vector memory controller.
//   Contents:
//     vmc_state_e    controller state encoding
//     vmc_len_width  width of a 0..LANES element count
//     vmc_lane_lsb   bit offset of a lane inside a packed vector image
//   Configuration: no macros are used in this file (VMC_STRIDE_EN is
//   consumed only by vmc_addr_gen).

package vmc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_TAIL,
        STORE,
        DONE
    } vmc_state_e;

    // Enough bits to hold every count from 0 up to and including LANES.
    function automatic int vmc_len_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    // Lane i of a packed vector occupies bits [i*dw +: dw].
    function automatic int vmc_lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/vmc_addr_gen.sv
// vmc_addr_gen
//   Running word-address generator for the vector memory controller.
//   The accumulator itself is the memory address register: 'load' seeds it
//   with the request base (and captures the stride), 'step' advances it by
//   one element. Arithmetic wraps modulo 2^AW.
//   Ports:
//     clk, rst       clock, asynchronous active-low reset
//     load           seed accumulator from base (and stride register)
//     step           advance accumulator by one element
//     base, stride   request start address and element step
//     addr           current element address (holds when idle)
//   Configuration:
//     VMC_STRIDE_EN  defined   : stride register honoured, 0 allowed
//                    undefined : step is a fixed +1, stride input ignored

module vmc_addr_gen
    import vmc_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] stride,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] addr_q, addr_d;

`ifdef VMC_STRIDE_EN
    logic [AW-1:0] stride_q, stride_d;

    // Seed base and stride together on accept; afterwards each step adds
    // the captured stride so a request is immune to later input changes.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        if (load) begin
            addr_d   = base;
            stride_d = stride;
        end else if (step) begin
            addr_d = addr_q + stride_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end
`else
    logic stride_unused;
    assign stride_unused = ^stride;

    // Unit-stride build: no stride register, the step is a plain increment.
    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = base;
        end else if (step) begin
            addr_d = addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end
`endif

    assign addr = addr_q;

endmodule

// File: rtl/vector_mem_ctrl.sv
// vector_mem_ctrl
//   Turns one vector load/store request into LANES-or-fewer consecutive
//   word accesses on a single-port synchronous memory (1-cycle read
//   latency), gathering loaded words into rd_vec or scattering wr_vec.
//   Ports:
//     clk, rst                  clock, asynchronous active-low reset
//     req_valid/req_ready       request handshake (ready only in IDLE)
//     req_we                    1 = store, 0 = load
//     req_base/stride/len       first word address, element step, count
//     wr_vec                    store image, lane i = bits [i*DW +: DW]
//     rd_vec                    load image, valid while done is high
//     done                      one-cycle completion pulse
//     busy                      accept through done, inclusive
//     mem_address/data/rden/wren/q   memory port
//   Configuration: VMC_STRIDE_EN (handled inside vmc_addr_gen) enables a
//   per-request stride; otherwise the stride is fixed at 1.

module vector_mem_ctrl
    import vmc_pkg::*;
#(
    parameter  int LANES = 8,
    parameter  int DW    = 32,
    parameter  int AW    = 32,
    localparam int LW    = vmc_len_width(LANES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [AW-1:0]       req_base,
    input  logic [AW-1:0]       req_stride,
    input  logic [LW-1:0]       req_len,
    input  logic [LANES*DW-1:0] wr_vec,
    output logic [LANES*DW-1:0] rd_vec,
    output logic                done,
    output logic                busy,
    output logic [AW-1:0]       mem_address,
    output logic [DW-1:0]       mem_data,
    output logic                mem_rden,
    output logic                mem_wren,
    input  logic [DW-1:0]       mem_q
);

    vmc_state_e          state_q, state_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [LW-1:0]       len_q, len_d;
    logic [LW-1:0]       cap_lane_q, cap_lane_d;
    logic                cap_valid_q, cap_valid_d;
    logic [LANES*DW-1:0] wr_vec_q, wr_vec_d;
    logic [LANES*DW-1:0] rd_vec_q, rd_vec_d;
    logic [DW-1:0]       mem_data_q, mem_data_d;
    logic                mem_rden_q, mem_rden_d;
    logic                mem_wren_q, mem_wren_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                req_ready_q, req_ready_d;

    logic                addr_load, addr_step;
    logic [LW-1:0]       len_clamped;
    logic [LW-1:0]       lane_next;
    logic                last_lane;

    assign len_clamped = (req_len > LW'(LANES)) ? LW'(LANES) : req_len;
    assign lane_next   = lane_q + LW'(1);
    assign last_lane   = (lane_q == len_q - LW'(1));

    vmc_addr_gen #(
        .AW(AW)
    ) u_addr_gen (
        .clk   (clk),
        .rst   (rst),
        .load  (addr_load),
        .step  (addr_step),
        .base  (req_base),
        .stride(req_stride),
        .addr  (mem_address)
    );

    // Next-state logic. All outputs are registered and derived from the
    // next state, so a strobe is high exactly during the cycles the FSM
    // sits in LOAD/STORE. The address and store data for lane i+1 are set
    // up on the same edge that retires lane i; on the last lane nothing
    // steps, so the address holds its final value while idle.
    //
    // Read capture trails issue by one cycle: a read strobed in cycle k is
    // sampled by the memory at the end of k and its data is on mem_q during
    // k+1, so cap_valid/cap_lane are simply the previous cycle's strobe and
    // lane. LOAD_TAIL exists only to catch the final lane's data.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        len_d       = len_q;
        wr_vec_d    = wr_vec_q;
        rd_vec_d    = rd_vec_q;
        mem_data_d  = mem_data_q;
        cap_valid_d = mem_rden_q;
        cap_lane_d  = lane_q;
        addr_load   = 1'b0;
        addr_step   = 1'b0;

        if (cap_valid_q) begin
            rd_vec_d[vmc_lane_lsb(int'(cap_lane_q), DW) +: DW] = mem_q;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    len_d    = len_clamped;
                    lane_d   = '0;
                    wr_vec_d = wr_vec;
                    // Lanes beyond len must read back as zero, so a load
                    // starts from a cleared image.
                    if (!req_we) begin
                        rd_vec_d = '0;
                    end
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_load = 1'b1;
                        if (req_we) begin
                            state_d    = STORE;
                            mem_data_d = wr_vec[DW-1:0];
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            LOAD: begin
                if (last_lane) begin
                    state_d = LOAD_TAIL;
                end else begin
                    lane_d    = lane_next;
                    addr_step = 1'b1;
                end
            end
            LOAD_TAIL: begin
                state_d = DONE;
            end
            STORE: begin
                if (last_lane) begin
                    state_d = DONE;
                end else begin
                    lane_d     = lane_next;
                    addr_step  = 1'b1;
                    mem_data_d = wr_vec_q[vmc_lane_lsb(int'(lane_next), DW) +: DW];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_rden_d  = (state_d == LOAD);
        mem_wren_d  = (state_d == STORE);
        done_d      = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        req_ready_d = (state_d == IDLE);
    end

    // Single state register. Reset aborts any request in flight and drops
    // the memory strobes without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            len_q       <= '0;
            cap_lane_q  <= '0;
            cap_valid_q <= 1'b0;
            wr_vec_q    <= '0;
            rd_vec_q    <= '0;
            mem_data_q  <= '0;
            mem_rden_q  <= 1'b0;
            mem_wren_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            len_q       <= len_d;
            cap_lane_q  <= cap_lane_d;
            cap_valid_q <= cap_valid_d;
            wr_vec_q    <= wr_vec_d;
            rd_vec_q    <= rd_vec_d;
            mem_data_q  <= mem_data_d;
            mem_rden_q  <= mem_rden_d;
            mem_wren_q  <= mem_wren_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rd_vec    = rd_vec_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign mem_data  = mem_data_q;
    assign mem_rden  = mem_rden_q;
    assign mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_vector_mem_ctrl.sv
// tb_vector_mem_ctrl
//   Directed, table-driven bench for vector_mem_ctrl with a 1024-word
//   behavioural memory (address bits [9:0]). Works with and without
//   VMC_STRIDE_EN; stride-specific vectors are selected by the same macro.

module tb_vector_mem_ctrl;

    localparam int LANES = 8;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LW    = 4;
    localparam int VW    = LANES * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_base = '0;
    logic [AW-1:0] req_stride = '0;
    logic [LW-1:0] req_len = '0;
    logic [VW-1:0] wr_vec = '0;
    logic [VW-1:0] rd_vec;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q = '0;

    logic [DW-1:0] tb_mem [0:1023];

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] base;
        logic [AW-1:0] stride;
        logic [LW-1:0] len;
        logic [AW-1:0] exp_stride;
        int            exp_lat;
        int            exp_cnt;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs[$];

    logic [AW-1:0] seen_addr[$];
    logic [DW-1:0] seen_data[$];
    int            seen_rd;
    int            seen_wr;
    logic          seen_both;
    logic          busy_first;
    logic          ready_first;
    logic [VW-1:0] rd_at_done;

    vector_mem_ctrl #(
        .LANES(LANES),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_base   (req_base),
        .req_stride (req_stride),
        .req_len    (req_len),
        .wr_vec     (wr_vec),
        .rd_vec     (rd_vec),
        .done       (done),
        .busy       (busy),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Behavioural synchronous memory: write on the edge, read data one
    // cycle after the read strobe is sampled.
    always @(posedge clk) begin
        if (mem_wren) tb_mem[mem_address[9:0]] = mem_data;
        if (mem_rden) mem_q <= tb_mem[mem_address[9:0]];
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Initial memory contents; 0x10..0x17 hold 0xA0..0xA7.
    function automatic logic [DW-1:0] init_word(input logic [9:0] idx);
        if (idx >= 10'h010 && idx <= 10'h017) return 32'hA0 + 32'(idx - 10'h010);
        return 32'hC000_0000 | 32'(idx);
    endfunction

    task automatic checkOutput(input string name, input logic [VW-1:0] actual,
                               input logic [VW-1:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic addVec(input logic we, input logic [AW-1:0] base,
                          input logic [AW-1:0] stride, input logic [LW-1:0] len,
                          input logic [AW-1:0] exp_stride, input int exp_lat,
                          input int exp_cnt, input logic [AW-1:0] exp_last);
        vec_t v;
        v.we = we; v.base = base; v.stride = stride; v.len = len;
        v.exp_stride = exp_stride; v.exp_lat = exp_lat;
        v.exp_cnt = exp_cnt; v.exp_last = exp_last;
        vecs.push_back(v);
    endtask

    // Present one request, wait for its accept edge, then watch each cycle
    // (sampled on the falling edge) until done. lat = n means done was seen
    // in the n-th cycle after the accept edge; -1 means it never came.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] base,
                                 input logic [AW-1:0] stride, input logic [LW-1:0] len,
                                 input logic [VW-1:0] wv, output int lat);
        seen_addr.delete();
        seen_data.delete();
        seen_rd   = 0;
        seen_wr   = 0;
        seen_both = 1'b0;
        lat       = -1;
        @(negedge clk);
        req_we = we; req_base = base; req_stride = stride; req_len = len;
        wr_vec = wv; req_valid = 1'b1;
        for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_valid   = 1'b0;
                busy_first  = busy;
                ready_first = req_ready;
            end
            if (mem_rden && mem_wren) seen_both = 1'b1;
            if (mem_rden) begin
                seen_rd++;
                seen_addr.push_back(mem_address);
            end
            if (mem_wren) begin
                seen_wr++;
                seen_addr.push_back(mem_address);
                seen_data.push_back(mem_data);
            end
            if (done) begin
                lat        = n;
                rd_at_done = rd_vec;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        logic [VW-1:0] store_img;
        logic [VW-1:0] last_load;
        logic [VW-1:0] exp_img;
        logic [AW-1:0] a;
        logic [AW-1:0] last_a;
        int            lat;
        int            done_count;
        vec_t          v;

        for (int i = 0; i < 1024; i++) tb_mem[i] = init_word(10'(i));
        for (int i = 0; i < LANES; i++) store_img[i*DW +: DW] = 32'((i + 1) * 17);
        last_load = '0;

        // Reset state.
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset req_ready", VW'(req_ready), VW'(1));
        checkOutput("reset busy", VW'(busy), VW'(0));
        checkOutput("reset done", VW'(done), VW'(0));
        checkOutput("reset mem_rden", VW'(mem_rden), VW'(0));
        checkOutput("reset mem_wren", VW'(mem_wren), VW'(0));
        checkOutput("reset mem_address", VW'(mem_address), VW'(0));
        checkOutput("reset mem_data", VW'(mem_data), VW'(0));
        checkOutput("reset rd_vec", rd_vec, VW'(0));
        rst = 1'b1;

        // we, base, stride, len, expected stride, latency, accesses, last address
        addVec(1'b0, 32'h0000_0010, 32'd1, 4'd8, 32'd1, 10, 8, 32'h0000_0017);
        addVec(1'b1, 32'h0000_0040, 32'd1, 4'd3, 32'd1,  4, 3, 32'h0000_0042);
        addVec(1'b0, 32'hFFFF_FFFE, 32'd1, 4'd4, 32'd1,  6, 4, 32'h0000_0001);
        addVec(1'b0, 32'h0000_0300, 32'd1, 4'd0, 32'd1,  1, 0, 32'h0000_0000);
        addVec(1'b0, 32'h0000_0200, 32'd1, 4'd9, 32'd1, 10, 8, 32'h0000_0207);
        addVec(1'b1, 32'h0000_0080, 32'd1, 4'd8, 32'd1,  9, 8, 32'h0000_0087);
        addVec(1'b0, 32'h0000_0030, 32'd1, 4'd2, 32'd1,  4, 2, 32'h0000_0031);
`ifdef VMC_STRIDE_EN
        addVec(1'b0, 32'h0000_0100, 32'd4, 4'd4, 32'd4,  6, 4, 32'h0000_010C);
        addVec(1'b0, 32'h0000_0100, 32'd0, 4'd4, 32'd0,  6, 4, 32'h0000_0100);
`else
        addVec(1'b0, 32'h0000_0100, 32'd7, 4'd4, 32'd1,  6, 4, 32'h0000_0103);
`endif

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            applyStimulus(v.we, v.base, v.stride, v.len, store_img, lat);
            checkOutput($sformatf("v%0d latency", k), VW'(lat), VW'(v.exp_lat));
            checkOutput($sformatf("v%0d access count", k),
                        VW'(v.we ? seen_wr : seen_rd), VW'(v.exp_cnt));
            checkOutput($sformatf("v%0d wrong-kind strobes", k),
                        VW'(v.we ? seen_rd : seen_wr), VW'(0));
            checkOutput($sformatf("v%0d rden&wren overlap", k), VW'(seen_both), VW'(0));
            checkOutput($sformatf("v%0d busy after accept", k), VW'(busy_first), VW'(1));
            checkOutput($sformatf("v%0d ready after accept", k), VW'(ready_first), VW'(0));
            for (int i = 0; i < seen_addr.size(); i++) begin
                a = v.base + 32'(i) * v.exp_stride;
                checkOutput($sformatf("v%0d address %0d", k, i), VW'(seen_addr[i]), VW'(a));
            end
            if (v.exp_cnt > 0) begin
                last_a = '1;
                if (seen_addr.size() > 0) last_a = seen_addr[seen_addr.size() - 1];
                checkOutput($sformatf("v%0d last address", k), VW'(last_a), VW'(v.exp_last));
            end
            if (!v.we) begin
                exp_img = '0;
                for (int i = 0; i < v.exp_cnt; i++) begin
                    a = v.base + 32'(i) * v.exp_stride;
                    exp_img[i*DW +: DW] = init_word(a[9:0]);
                end
                for (int i = 0; i < LANES; i++)
                    checkOutput($sformatf("v%0d rd_vec lane %0d", k, i),
                                VW'(rd_at_done[i*DW +: DW]), VW'(exp_img[i*DW +: DW]));
                last_load = exp_img;
            end else begin
                for (int i = 0; i < seen_data.size(); i++)
                    checkOutput($sformatf("v%0d mem_data %0d", k, i),
                                VW'(seen_data[i]), VW'(store_img[i*DW +: DW]));
                for (int i = 0; i < v.exp_cnt; i++) begin
                    a = v.base + 32'(i);
                    checkOutput($sformatf("v%0d memory word %0d", k, i),
                                VW'(tb_mem[a[9:0]]), VW'(store_img[i*DW +: DW]));
                end
                a = v.base + 32'(v.exp_cnt);
                checkOutput($sformatf("v%0d word past end untouched", k),
                            VW'(tb_mem[a[9:0]]), VW'(init_word(a[9:0])));
                checkOutput($sformatf("v%0d rd_vec held over store", k), rd_at_done, last_load);
            end
        end

        // Reset asserted in the third cycle of an 8-lane load.
        @(negedge clk);
        req_we = 1'b0; req_base = 32'h10; req_stride = 32'd1; req_len = 4'd8;
        req_valid = 1'b1;
        for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort rden before reset", VW'(mem_rden), VW'(1));
        #2 rst = 1'b0;
        #1;
        checkOutput("abort rden dropped", VW'(mem_rden), VW'(0));
        checkOutput("abort wren low", VW'(mem_wren), VW'(0));
        checkOutput("abort req_ready", VW'(req_ready), VW'(1));
        checkOutput("abort busy", VW'(busy), VW'(0));
        checkOutput("abort rd_vec cleared", rd_vec, VW'(0));
        done_count = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) done_count++;
        end
        checkOutput("abort no done pulse", VW'(done_count), VW'(0));

        // A normal load after the abort.
        applyStimulus(1'b0, 32'h20, 32'd1, 4'd3, store_img, lat);
        checkOutput("post-abort latency", VW'(lat), VW'(5));
        checkOutput("post-abort reads", VW'(seen_rd), VW'(3));
        exp_img = '0;
        for (int i = 0; i < 3; i++) exp_img[i*DW +: DW] = init_word(10'(32'h20 + i));
        checkOutput("post-abort rd_vec", rd_at_done, exp_img);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
